// File: rtl/updown_ctrl_debounce.sv
// Pushbutton synchroniser and debouncer that toggles the counter's direction bit
// once per accepted press, and also exports a press pulse and the debounced level.
module updown_ctrl_debounce #(
    parameter int   DEBOUNCE_CYCLES = 8,
    parameter int   CNT_W           = 4,
    parameter logic CTRL_INIT       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic ctrl,
    output logic press_pulse,
    output logic btn_stable
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        PRESSED   = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ctrl;
    logic             w_ctrl_nxt;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic             r_stable;
    logic             w_stable_nxt;

    // Synchroniser flops are also cleared so an X on btn_raw cannot reach the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ctrl   <= CTRL_INIT;
            r_pulse  <= 1'b0;
            r_stable <= 1'b0;
        end else begin
            r_sync1  <= btn_raw;
            r_sync2  <= r_sync1;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ctrl   <= w_ctrl_nxt;
            r_pulse  <= w_pulse_nxt;
            r_stable <= w_stable_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ctrl_nxt   = r_ctrl;
        w_pulse_nxt  = 1'b0;
        w_stable_nxt = r_stable;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt  = PRESSED;
                    w_cnt_nxt    = '0;
                    w_stable_nxt = 1'b1;
                    w_pulse_nxt  = 1'b1;
                    w_ctrl_nxt   = ~r_ctrl;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!r_sync2) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LOW: begin
                // Release only drops the level; direction changes on presses alone.
                if (r_sync2) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt  = IDLE;
                    w_cnt_nxt    = '0;
                    w_stable_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign ctrl        = r_ctrl;
    assign press_pulse = r_pulse;
    assign btn_stable  = r_stable;

endmodule
